// File: rtl/sprite_layer_engine.sv
// Purpose : multi-sprite car renderer for the road window with double-buffered positions and collision flags.
// Latency : pixel_x/pixel_y at cycle t produce rgb/on/hit_id at t+2; one pixel per cycle, fully pipelined.
// Backpressure: none; the pixel stream never stalls and a new pixel is accepted every cycle.
//
// Ports:
//   pclk, reset            pixel clock; synchronous active-high reset
//   pixel_x, pixel_y       current raster position (stage 0)
//   frame_start            one-cycle pulse in vertical blank; copies shadow -> active and latches collisions
//   spr_wr, spr_idx, spr_x, spr_y, spr_owner, spr_en
//                          shadow register write port, usable at any time
//   rgb, on, hit_id        registered pixel colour, opaque flag and winning sprite index
//   collision              per-sprite collision flags for the previous frame
//
// Optional feature: define SPRITE_COLLISION_EN to build the collision accumulator.
// Without it, collision is tied to zero and rendering is unchanged.
//
// BITMAP_FILE names the bitmap image used by builds that preload the ROM from a file.
// This netlist carries a built-in procedural bitmap so it elaborates with no external files.

module sprite_layer_engine #(
  parameter int         NUM_SPRITES = 4,
  parameter int         SPR_W       = 16,
  parameter int         SPR_H       = 32,
  parameter int         NUM_OWNERS  = 8,
  parameter logic [1:0] ROAD_SEL    = 2'b01,
  parameter             BITMAP_FILE = "car_bitmap.mem",
  localparam int        IDX_W       = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic                   pclk,
  input  logic                   reset,
  input  logic [9:0]             pixel_x,
  input  logic [9:0]             pixel_y,
  input  logic                   frame_start,
  input  logic                   spr_wr,
  input  logic [IDX_W-1:0]       spr_idx,
  input  logic [7:0]             spr_x,
  input  logic [9:0]             spr_y,
  input  logic [2:0]             spr_owner,
  input  logic                   spr_en,
  output logic [2:0]             rgb,
  output logic                   on,
  output logic [IDX_W-1:0]       hit_id,
  output logic [NUM_SPRITES-1:0] collision
);

  localparam int LX_W   = $clog2(SPR_W);
  localparam int LY_W   = $clog2(SPR_H);
  localparam int LINE_W = SPR_W * 3;
  localparam int ADDR_W = $clog2(NUM_OWNERS * SPR_H);

  typedef struct packed {
    logic [7:0] x;
    logic [9:0] y;
    logic [2:0] owner;
    logic       en;
  } spr_t;

  // Bitmap line at ROM address a; pixel c lives in bits [c*3 +: 3].
  function automatic logic [LINE_W-1:0] rom_line(input logic [ADDR_W-1:0] a);
    logic [LINE_W-1:0] l;
    int                ai;
    l  = '0;
    ai = int'(a);
    for (int c = 0; c < SPR_W; c++) begin
      l[c*3 +: 3] = 3'((ai * 3 + c * 5 + (ai >> 3)) & 7);
    end
    return l;
  endfunction

  spr_t shadow [NUM_SPRITES];
  spr_t active [NUM_SPRITES];

  // Shadow/active banks. The active copy reads the shadow value from before
  // any write in the same cycle, so a coincident write shows next frame.
  always_ff @(posedge pclk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (frame_start) begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
          active[i] <= shadow[i];
        end
      end
      if (spr_wr && (32'(spr_idx) < NUM_SPRITES)) begin
        shadow[spr_idx] <= {spr_x, spr_y, spr_owner, spr_en};
      end
    end
  end

  // Stage 0: hit test and local coordinates. Widening to 9/11 bits keeps
  // sprites near the right/bottom edge from wrapping back into view.
  logic [NUM_SPRITES-1:0] hit_d;
  logic [LX_W-1:0]        lx_d   [NUM_SPRITES];
  logic [ADDR_W-1:0]      addr_d [NUM_SPRITES];

  always_comb begin
    logic [8:0]      x9;
    logic [8:0]      px9;
    logic [10:0]     y11;
    logic [10:0]     py11;
    logic [LY_W-1:0] ly;
    hit_d = '0;
    x9    = '0;
    px9   = {1'b0, pixel_x[7:0]};
    y11   = '0;
    py11  = {1'b0, pixel_y};
    ly    = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      x9        = {1'b0, active[i].x};
      y11       = {1'b0, active[i].y};
      hit_d[i]  = active[i].en && (pixel_x[9:8] == ROAD_SEL) &&
                  (px9 >= x9) && (px9 < x9 + 9'(SPR_W)) &&
                  (py11 >= y11) && (py11 < y11 + 11'(SPR_H));
      lx_d[i]   = LX_W'(px9 - x9);
      ly        = LY_W'(py11 - y11);
      addr_d[i] = ADDR_W'(32'(active[i].owner) * SPR_H + 32'(ly));
    end
  end

  // Stage 1: hit flags, column offset and the per-sprite ROM read port.
  logic [NUM_SPRITES-1:0] hit_q;
  logic [LX_W-1:0]        lx_q   [NUM_SPRITES];
  logic [LINE_W-1:0]      line_q [NUM_SPRITES];

  always_ff @(posedge pclk) begin
    if (reset) begin
      hit_q <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        lx_q[i]   <= '0;
        line_q[i] <= '0;
      end
    end else begin
      hit_q <= hit_d;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        lx_q[i]   <= lx_d[i];
        line_q[i] <= rom_line(addr_d[i]);
      end
    end
  end

  // Stage 2: pixel extraction and priority. Walking from the highest index
  // down lets the lowest opaque index win.
  logic [NUM_SPRITES-1:0] opaque;
  logic [2:0]             sel_rgb;
  logic                   sel_on;
  logic [IDX_W-1:0]       sel_id;

  always_comb begin
    int         base;
    logic [2:0] p;
    opaque  = '0;
    sel_rgb = '0;
    sel_on  = 1'b0;
    sel_id  = '0;
    base    = 0;
    p       = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      base = int'(lx_q[i]) * 3;
      p    = line_q[i][base +: 3];
      if (hit_q[i] && (p != 3'b000)) begin
        opaque[i] = 1'b1;
        sel_rgb   = p;
        sel_on    = 1'b1;
        sel_id    = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      rgb    <= '0;
      on     <= 1'b0;
      hit_id <= '0;
    end else begin
      rgb    <= sel_rgb;
      on     <= sel_on;
      hit_id <= sel_id;
    end
  end

`ifdef SPRITE_COLLISION_EN
  logic [NUM_SPRITES-1:0] acc;
  logic [NUM_SPRITES-1:0] acc_d;

  always_comb begin
    acc_d = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      acc_d[i] = opaque[i] && (|(opaque & ~(NUM_SPRITES'(1) << i)));
    end
  end

  // A hit seen in the frame_start cycle seeds the new frame's accumulator.
  always_ff @(posedge pclk) begin
    if (reset) begin
      acc       <= '0;
      collision <= '0;
    end else if (frame_start) begin
      collision <= acc;
      acc       <= acc_d;
    end else begin
      acc <= acc | acc_d;
    end
  end
`else
  assign collision = '0;
`endif

endmodule

// File: tb/tb_sprite_layer_engine.sv
module tb_sprite_layer_engine;

  localparam int NS = 4;

  logic          pclk = 1'b0;
  logic          reset;
  logic [9:0]    pixel_x;
  logic [9:0]    pixel_y;
  logic          frame_start;
  logic          spr_wr;
  logic [1:0]    spr_idx;
  logic [7:0]    spr_x;
  logic [9:0]    spr_y;
  logic [2:0]    spr_owner;
  logic          spr_en;
  logic [2:0]    rgb;
  logic          on;
  logic [1:0]    hit_id;
  logic [NS-1:0] collision;

  always #5 pclk = ~pclk;

  sprite_layer_engine #(
    .NUM_SPRITES(NS), .SPR_W(16), .SPR_H(32), .NUM_OWNERS(8), .ROAD_SEL(2'b01)
  ) dut (
    .pclk(pclk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .frame_start(frame_start), .spr_wr(spr_wr), .spr_idx(spr_idx),
    .spr_x(spr_x), .spr_y(spr_y), .spr_owner(spr_owner), .spr_en(spr_en),
    .rgb(rgb), .on(on), .hit_id(hit_id), .collision(collision)
  );

  typedef struct {
    int            due;
    bit            is_coll;
    logic [2:0]    rgb;
    logic          on;
    logic [1:0]    id;
    logic [NS-1:0] coll;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge pclk) cyc <= cyc + 1;

  // Reference model state: sprite banks as plain integers.
  int            sh_x[NS], sh_y[NS], sh_o[NS];
  bit            sh_en[NS];
  int            ac_x[NS], ac_y[NS], ac_o[NS];
  bit            ac_en[NS];
  logic [NS-1:0] m_acc;
  logic [NS-1:0] m_coll;
  bit            prev_reset;

  // Contents of the car bitmap ROM: colour of column c on ROM line addr.
  function automatic logic [2:0] rom_pix(int addr, int c);
    int v;
    v = addr * 3 + c * 5 + (addr >> 3);
    return 3'(v & 7);
  endfunction

  // Issue the current inputs for one cycle: predict the response, push it, advance.
  task automatic cycle();
    exp_t          e;
    exp_t          t;
    exp_t          ce;
    logic [NS-1:0] opq;
    int            px, py, lx, ly;
    px  = int'(pixel_x);
    py  = int'(pixel_y);
    opq = '0;
    // A pixel one edge away from its output is flushed by a newly raised reset.
    if (reset && !prev_reset) begin
      for (int k = 0; k < q.size(); k++) begin
        if (!q[k].is_coll && q[k].due == cyc + 1) begin
          t = q[k]; t.rgb = 0; t.on = 0; t.id = 0; q[k] = t;
        end
      end
    end
    if (!reset) begin
      for (int i = 0; i < NS; i++) begin
        lx = (px % 256) - ac_x[i];
        ly = py - ac_y[i];
        if (ac_en[i] && (px / 256 == 1) && lx >= 0 && lx < 16 && ly >= 0 && ly < 32)
          if (rom_pix(ac_o[i] * 32 + ly, lx) != 3'b000) opq[i] = 1'b1;
      end
    end
    e.due = cyc + 2; e.is_coll = 0; e.rgb = 0; e.on = 0; e.id = 0; e.coll = 0;
    for (int i = 0; i < NS; i++) begin
      if (opq[i] && !e.on) begin
        e.on  = 1'b1;
        e.rgb = rom_pix(ac_o[i] * 32 + py - ac_y[i], (px % 256) - ac_x[i]);
        e.id  = 2'(i);
      end
    end
`ifdef SPRITE_COLLISION_EN
    if ($countones(opq) >= 2) m_acc = m_acc | opq;
`endif
    if (reset) begin
      for (int i = 0; i < NS; i++) begin
        sh_x[i] = 0; sh_y[i] = 0; sh_o[i] = 0; sh_en[i] = 0;
        ac_x[i] = 0; ac_y[i] = 0; ac_o[i] = 0; ac_en[i] = 0;
      end
      m_acc  = '0;
      m_coll = '0;
    end else begin
      if (frame_start) begin
        m_coll = m_acc;
        m_acc  = '0;
        for (int i = 0; i < NS; i++) begin
          ac_x[i] = sh_x[i]; ac_y[i] = sh_y[i]; ac_o[i] = sh_o[i]; ac_en[i] = sh_en[i];
        end
      end
      if (spr_wr) begin
        sh_x[spr_idx] = int'(spr_x); sh_y[spr_idx] = int'(spr_y);
        sh_o[spr_idx] = int'(spr_owner); sh_en[spr_idx] = spr_en;
      end
    end
    ce.due = cyc + 1; ce.is_coll = 1; ce.rgb = 0; ce.on = 0; ce.id = 0; ce.coll = m_coll;
    q.push_back(ce);
    q.push_back(e);
    prev_reset = reset;
    @(posedge pclk);
    #1;
    frame_start = 1'b0;
    spr_wr      = 1'b0;
  endtask

  task automatic pix(int x, int y);
    pixel_x = 10'(x);
    pixel_y = 10'(y);
    cycle();
  endtask

  task automatic wr(int idx, int x, int y, int o, bit en);
    spr_wr = 1'b1; spr_idx = 2'(idx); spr_x = 8'(x); spr_y = 10'(y);
    spr_owner = 3'(o); spr_en = en;
    pix(0, 0);
  endtask

  // Vertical blank with a frame_start pulse surrounded by off-window pixels.
  task automatic blank_fs();
    for (int k = 0; k < 3; k++) pix(0, 600);
    frame_start = 1'b1;
    pix(0, 600);
    pix(0, 600);
  endtask

  task automatic near_sprite();
    int i;
    i = $urandom_range(0, NS - 1);
    pix(256 + ac_x[i] + int'($urandom_range(0, 19)) - 2, ac_y[i] + int'($urandom_range(0, 35)) - 2);
  endtask

  // Monitor: compares every expectation when its due cycle is reached.
  exp_t m_e;
  initial begin
    forever begin
      @(negedge pclk);
      while (q.size() > 0 && q[0].due <= cyc) begin
        m_e = q.pop_front();
        checks++;
        if (m_e.is_coll) begin
          if (collision !== m_e.coll) begin
            errors++;
            $display("FAIL collision cyc=%0d got=%b want=%b", cyc, collision, m_e.coll);
          end
        end else if ({rgb, on, hit_id} !== {m_e.rgb, m_e.on, m_e.id}) begin
          errors++;
          $display("FAIL pixel cyc=%0d got rgb=%b on=%b id=%0d want rgb=%b on=%b id=%0d",
                   cyc, rgb, on, hit_id, m_e.rgb, m_e.on, m_e.id);
        end
      end
    end
  end

  initial begin
    int n;
    reset = 1'b1; pixel_x = '0; pixel_y = '0; frame_start = 1'b0; spr_wr = 1'b0;
    spr_idx = '0; spr_x = '0; spr_y = '0; spr_owner = '0; spr_en = 1'b0;
    prev_reset = 1'b0; m_acc = '0; m_coll = '0;
    for (int i = 0; i < NS; i++) begin
      sh_x[i] = 0; sh_y[i] = 0; sh_o[i] = 0; sh_en[i] = 0;
      ac_x[i] = 0; ac_y[i] = 0; ac_o[i] = 0; ac_en[i] = 0;
    end
    for (int k = 0; k < 3; k++) pix(0, 0);
    reset = 1'b0;

    // Empty scene: nothing drawn anywhere.
    for (int k = 0; k < 64; k++) pix(256 + int'($urandom_range(0, 255)), int'($urandom_range(0, 400)));
    blank_fs();

    // Single sprite, left/right and bottom half-open edges.
    wr(0, 40, 100, 1, 1'b1);
    blank_fs();
    pix(296, 100); pix(312, 100); pix(295, 100); pix(311, 131); pix(311, 132); pix(311, 99);

    // Overlap of sprites 0 and 2, then collision latched at next frame.
    wr(2, 45, 110, 3, 1'b1);
    blank_fs();
    pix(306, 120);
    for (int c = 40; c < 64; c++) pix(256 + c, 120);
    blank_fs();
    for (int k = 0; k < 4; k++) pix(0, 600);

    // Right-edge clipping, no wrap into the next window.
    wr(1, 250, 200, 4, 1'b1);
    blank_fs();
    for (int c = 246; c < 256; c++) pix(256 + c, 210);
    pix(512, 210); pix(513, 210); pix(517, 210); pix(768 + 250, 210);

    // Write coincident with frame_start: old x now, new x next frame.
    for (int k = 0; k < 3; k++) pix(0, 600);
    spr_wr = 1'b1; spr_idx = 2'd1; spr_x = 8'd80; spr_y = 10'd200; spr_owner = 3'd4; spr_en = 1'b1;
    frame_start = 1'b1;
    pix(0, 600);
    pix(0, 600);
    for (int c = 78; c < 98; c++) pix(256 + c, 210);
    for (int c = 248; c < 256; c++) pix(256 + c, 210);
    blank_fs();
    for (int c = 78; c < 98; c++) pix(256 + c, 210);

    // Disabled sprite never shows.
    wr(1, 80, 200, 4, 1'b0);
    blank_fs();
    for (int c = 78; c < 98; c++) pix(256 + c, 210);

    // Randomised scenes.
    for (int f = 0; f < 10; f++) begin
      n = int'($urandom_range(3, 6));
      for (int k = 0; k < n; k++)
        wr(int'($urandom_range(0, NS - 1)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 300)), int'($urandom_range(0, 7)), ($urandom_range(0, 4) != 0));
      blank_fs();
      for (int k = 0; k < 150; k++) begin
        if ($urandom_range(0, 19) == 0)
          wr(int'($urandom_range(0, NS - 1)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 300)), int'($urandom_range(0, 7)), 1'b1);
        else
          near_sprite();
      end
    end
    blank_fs();

    // Reset in the middle of a scanline; sprites stay hidden afterwards.
    for (int k = 0; k < 10; k++) near_sprite();
    reset = 1'b1;
    near_sprite();
    near_sprite();
    reset = 1'b0;
    for (int k = 0; k < 20; k++) pix(256 + int'($urandom_range(0, 255)), int'($urandom_range(0, 330)));
    blank_fs();
    for (int k = 0; k < 20; k++) pix(256 + int'($urandom_range(0, 255)), int'($urandom_range(0, 330)));

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge pclk);
    #1;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_layer_engine.md
# sprite_layer_engine

Multi-sprite renderer for the road window: it replaces the single-car graphic controller with NUM_SPRITES independently positioned cars. Each car has its own bitmap (owner) selection, per-sprite enable, fixed priority and transparent-colour handling. Positions are double-buffered so game logic can update them at any time without tearing. A fixed two-cycle pipeline feeds the pixel mux, and the block reports pixel-exact, frame-accurate sprite-to-sprite collisions to the game FSM.

## Interface
- NUM_SPRITES, 4, number of sprite channels (1..8)
- SPR_W, 16, sprite width in pixels (power of two)
- SPR_H, 32, sprite height in lines (power of two)
- NUM_OWNERS, 8, bitmaps stored in ROM, each SPR_H lines of SPR_W*3 bits
- ROAD_SEL, 2'b01, value of pixel_x[9:8] that enables the road window
- BITMAP_FILE, "car_bitmap.mem", $readmemb init file for internal ROM

Ports:
- pclk  in  1  pixel clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- pixel_x  in  10  current pixel column
- pixel_y  in  10  current pixel line
- frame_start  in  1  one-cycle pulse at start of vertical blank
- spr_wr  in  1  write strobe for shadow sprite registers
- spr_idx  in  clog2(NUM_SPRITES)  sprite being written
- spr_x  in  8  left edge inside road window
- spr_y  in  10  top line
- spr_owner  in  3  bitmap select
- spr_en  in  1  sprite visible
- rgb  out  3  pixel colour, registered
- on  out  1  some opaque sprite pixel present, registered
- hit_id  out  clog2(NUM_SPRITES)  index of the winning sprite, registered
- collision  out  NUM_SPRITES  per-sprite collision flags for the previous frame

## Operation
- Shadow bank: spr_wr writes {x,y,owner,en} into shadow[spr_idx]; out-of-range idx is ignored.
- Active bank: on frame_start, all shadow entries are copied to active. If spr_wr and frame_start occur in the same cycle, active receives the pre-write shadow; the write lands in shadow and shows next frame.
- Hit test per sprite i (active bank only): en && pixel_x[9:8]==ROAD_SEL && x <= pixel_x[7:0] < x+SPR_W && y <= pixel_y < y+SPR_H. The interval is half-open.
- Bounds arithmetic uses 9-bit x and 11-bit y. Columns past 255 and lines past 1023 are simply not drawn; there is no wrap.
- Local coordinates: lx = pixel_x[7:0]-x (log2 SPR_W bits), ly = pixel_y-y (log2 SPR_H bits).
- ROM address = owner*SPR_H + ly. Each sprite has its own synchronous read port with 1-cycle latency.
- Pixel of sprite i is line[lx*3 +: 3]. 3'b000 is transparent; a transparent pixel is not opaque.
- Priority: the lowest index with an opaque pixel wins and drives rgb/hit_id with on=1. If no sprite is opaque: on=0, rgb=000, hit_id=0.
- Collision: a per-frame accumulator bit i is set when sprite i is opaque and at least one other sprite is opaque on the same pixel.
  - On frame_start, the accumulator is transferred to collision and then cleared.
  - An accumulation in the same cycle as frame_start belongs to the new frame.
- Reset: shadow and active banks cleared (all en=0). Outputs are rgb=0, on=0, hit_id=0, collision=0.

## Timing
- Latency: pixel_x/pixel_y at cycle t produce rgb/on/hit_id at t+2, fully pipelined with one pixel per cycle.
  - Stage 1 registers hit flags, lx, and the ROM line.
  - Stage 2 registers the mux and priority result.
- frame_start is applied at stage 0, so pixels already in flight use the old active bank; frame_start must arrive during blank.
- collision updates one cycle after frame_start and stays stable for the whole frame.
- Reset mid-frame takes effect the next edge. Pipeline registers are cleared, so the two outputs following reset are on=0.

## Configuration
- SPRITE_COLLISION_EN defined: accumulator and collision logic built as described.
- Not defined: collision tied to 0 and no accumulator registers are synthesised. Rendering is unchanged.

## Test plan
- Reset, then scan with no writes: on=0, rgb=000 on every pixel, collision=0.
- Write sprite 0 {x=40,y=100,owner=1,en=1}, then pulse frame_start.
  - Pixel (256+40,100) → rgb = ROM[32][2:0] and on=1 exactly 2 cycles later.
  - Pixel (256+56,100) → on=0 (half-open edge).
- Sprites 0 and 2 overlap at (256+50,120), both opaque → rgb from sprite 0, hit_id=0. During the next frame, collision=4'b0101.
- Sprite 1 at x=250 → columns 250..255 drawn and pixel_x=512 not drawn (no wrap). Sprite 1 with en=0 → never on.
- spr_wr x=80 coincident with frame_start → current frame shows the old x; next frame shows x=80.
- Assert reset mid-scanline → rgb/on/hit_id/collision all zero by the 2nd cycle after reset is applied. Sprites stay hidden until rewritten.
